data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Load/store data-memory responder. Serves the issue stage's load address port: accepts word addresses, returns load data with a valid flag after a fixed latency.
- Also accepts committed stores with byte enables.
- Sits between the issue stage's memory FU and the on-chip data RAM.
- Replaces the undefined-data-as-not-ready convention with an explicit valid/error handshake.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- READ_LAT, 2, load latency in cycles from request acceptance to o_rd_valid; legal range 1..4.

Ports:
- i_clk  input  1  clock, all state updates on the rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_rd_req  input  1  load request valid
- i_rd_addr  input  32  load byte address
- o_rd_valid  output  1  load response valid, one-cycle pulse per accepted request
- o_rd_data  output  32  load response data; 0 when o_rd_valid=0 or on error
- o_rd_err  output  1  response error: misaligned or out-of-range; qualified by o_rd_valid
- i_wr_req  input  1  store request valid
- i_wr_addr  input  32  store byte address
- i_wr_data  input  32  store data
- i_wr_be  input  4  byte enables; bit n selects byte n (little-endian)
- o_wr_err  output  1  registered one cycle after a store that was dropped as misaligned or out-of-range

Behaviour:
- Reset (i_rst_n=0, asynchronous):
  - o_rd_valid=0, o_rd_data=0, o_rd_err=0, o_wr_err=0.
  - All READ_LAT pipeline valid bits cleared.
  - Array contents are not cleared.
  - Reset mid-flight discards every outstanding load; no response is produced for it after reset releases.
- Requests are always accepted; no backpressure. One load and one store may be presented in the same cycle.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Load error conditions:
  - Misaligned: addr[1:0]!=0.
  - Out-of-range: addr >= 4*DEPTH_WORDS.
- Load pipeline:
  - Stage 0 reads the array in the acceptance cycle.
  - Data, error and valid then shift through READ_LAT registered stages.
  - o_rd_valid rises exactly READ_LAT rising edges after the edge that sampled i_rd_req=1.
  - Back-to-back loads give back-to-back responses, in order, with one response per request.
- Load error response: o_rd_valid=1, o_rd_err=1, o_rd_data=0.
- Store:
  - Written on the acceptance edge; only bytes with i_wr_be[n]=1 are updated.
  - i_wr_be=0000 is a no-op and is not an error.
  - Misaligned or out-of-range store: array unchanged, o_wr_err=1 for exactly one cycle.
- Same-cycle load and store to the same word: the load returns the pre-store value (read-before-write).
- Store to a word with a load already in flight: the in-flight load keeps its stage-0 value, unless the optional feature is enabled.
- Reads of never-written words return whatever the array holds. Simulation initialises the array to 0.

Optional Feature:
- Macro: DATA_MEM_STORE_FWD_EN.
- When defined:
  - Every in-flight load stage whose word index matches an accepted, non-erroring store has the enabled bytes replaced by i_wr_data on that edge.
  - Same-cycle load and store to the same word then returns the post-store value.
  - Loads always observe the youngest store accepted before their response.
- When undefined: read-before-write as described in Behaviour; no comparators are instantiated.

Test Plan:
- Reset with READ_LAT=2: store 0xDEADBEEF to 0x10 (be=1111), then load 0x10. o_rd_valid pulses 2 cycles after the request, with o_rd_data=0xDEADBEEF and o_rd_err=0.
- Byte-enable merge: write 0xAABBCCDD to 0x20, then 0x11223344 with be=0101. Load 0x20 returns 0xAA22CC44.
- Streaming: 4 back-to-back loads to 0x0, 0x4, 0x8, 0xC holding 1, 2, 3, 4. Four consecutive o_rd_valid cycles return 1, 2, 3, 4 in order.
- Errors: load 0x6 gives valid=1, err=1, data=0. Load 4*DEPTH_WORDS gives err=1. Store to 0x3 gives o_wr_err=1 for one cycle and a later load of 0x0 is unchanged.
- Hazard: 0x40 holds 5. Same-cycle load and store 9 to 0x40 returns 5 without DATA_MEM_STORE_FWD_EN and 9 with it. A store 7 one cycle after the load (READ_LAT=2) likewise returns 5 without the macro and 7 with it.
- Reset mid-flight: issue a load, assert i_rst_n=0 before the response, then release. No o_rd_valid appears, and the array still holds its pre-reset data.

Source files
------------

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Load/store responder placed between the issue stage's memory functional
// unit and the on-chip data RAM. Every load request is accepted. Each
// accepted load produces exactly one response. The response appears
// READ_LAT rising edges after the edge that accepted the load, and it
// carries an explicit valid/error indication. Stores are committed on the
// edge that accepts them, and only the bytes selected by the byte enables
// are written. A load and a store may both be presented in the same cycle.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words in the array (power of two)
//   READ_LAT     cycles from load acceptance to o_rd_valid (1..4)
//
// Ports:
//   i_clk       clock; all state updates on the rising edge
//   i_rst_n     asynchronous active-low reset; clears the load pipeline
//               and the error flags but leaves the array contents intact
//   i_rd_req    load request valid
//   i_rd_addr   load byte address
//   o_rd_valid  one-cycle response pulse for each accepted load
//   o_rd_data   load data; zero when not valid or when the load failed
//   o_rd_err    load was misaligned or out of range (qualified by valid)
//   i_wr_req    store request valid
//   i_wr_addr   store byte address
//   i_wr_data   store data
//   i_wr_be     byte enables; bit n selects byte n (little-endian)
//   o_wr_err    pulses one cycle after a store that was dropped because
//               its address was misaligned or out of range
//
// Build option:
//   DATA_MEM_STORE_FWD_EN  When defined, an accepted store patches every
//                          in-flight load to the same word. This covers a
//                          load accepted in the same cycle, so loads see
//                          the youngest store accepted before their
//                          response. When undefined, a load returns the
//                          value the array held in its acceptance cycle
//                          (read-before-write).
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int READ_LAT    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rd_req,
    input  logic [31:0] i_rd_addr,
    output logic        o_rd_valid,
    output logic [31:0] o_rd_data,
    output logic        o_rd_err,
    input  logic        i_wr_req,
    input  logic [31:0] i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_wr_be,
    output logic        o_wr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // Stage 0 captures the array read on the acceptance edge. READ_LAT more
    // stages follow it, so the last stage becomes valid exactly READ_LAT
    // edges after the acceptance edge.
    localparam int NSTG = READ_LAT + 1;

    // Replace the bytes selected by be with the matching bytes of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic          rd_bad;
    logic          wr_bad;
    logic          wr_ok;
    logic [31:0]   rd_word;
    logic [31:0]   cap_data;

    logic          pipe_valid [NSTG];
    logic          pipe_err   [NSTG];
    logic [31:0]   pipe_data  [NSTG];
    logic [31:0]   fwd_data   [NSTG-1];
`ifdef DATA_MEM_STORE_FWD_EN
    logic [AW-1:0] pipe_idx   [NSTG-1];
`endif

    // Address decode. The array size is a power of two, so an address is
    // out of range exactly when any bit above the word index is set.
    assign rd_idx  = i_rd_addr[AW+1:2];
    assign wr_idx  = i_wr_addr[AW+1:2];
    assign rd_bad  = (i_rd_addr[1:0] != 2'b00) || (i_rd_addr[31:AW+2] != '0);
    assign wr_bad  = (i_wr_addr[1:0] != 2'b00) || (i_wr_addr[31:AW+2] != '0);
    assign wr_ok   = i_wr_req && !wr_bad;
    assign rd_word = mem[rd_idx];

    // Value that stage 0 captures. The array is read asynchronously, so the
    // read sees the pre-store contents even when a store to the same word
    // lands on the same edge. Failed loads carry zero data.
    always_comb begin
        cap_data = rd_bad ? 32'h0 : rd_word;
`ifdef DATA_MEM_STORE_FWD_EN
        if (wr_ok && !rd_bad && (rd_idx == wr_idx)) begin
            cap_data = merge_bytes(cap_data, i_wr_data, i_wr_be);
        end
`endif
    end

    // Next data for each stage that can still shift forward. When forwarding
    // is enabled, a valid, non-erroring load to the stored word takes the
    // enabled store bytes. The final stage is already being presented, so
    // it is never patched.
    always_comb begin
        for (int s = 0; s < NSTG-1; s++) begin
            fwd_data[s] = pipe_data[s];
`ifdef DATA_MEM_STORE_FWD_EN
            if (wr_ok && pipe_valid[s] && !pipe_err[s] && (pipe_idx[s] == wr_idx)) begin
                fwd_data[s] = merge_bytes(pipe_data[s], i_wr_data, i_wr_be);
            end
`endif
        end
    end

    // Load pipeline. Clearing it on reset discards every outstanding load.
    // Data is zero whenever a stage is empty or holds a failed load, so the
    // output needs no extra gating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NSTG; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_err[s]   <= 1'b0;
                pipe_data[s]  <= 32'h0;
            end
`ifdef DATA_MEM_STORE_FWD_EN
            for (int s = 0; s < NSTG-1; s++) begin
                pipe_idx[s] <= '0;
            end
`endif
        end else begin
            pipe_valid[0] <= i_rd_req;
            pipe_err[0]   <= i_rd_req && rd_bad;
            pipe_data[0]  <= i_rd_req ? cap_data : 32'h0;
            for (int s = 1; s < NSTG; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_err[s]   <= pipe_err[s-1];
                pipe_data[s]  <= fwd_data[s-1];
            end
`ifdef DATA_MEM_STORE_FWD_EN
            pipe_idx[0] <= rd_idx;
            for (int s = 1; s < NSTG-1; s++) begin
                pipe_idx[s] <= pipe_idx[s-1];
            end
`endif
        end
    end

    // Array write port. The array has no reset, so its contents survive
    // i_rst_n. A store with all byte enables low rewrites the word with its
    // own value, so it leaves the word unchanged.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= merge_bytes(mem[wr_idx], i_wr_data, i_wr_be);
        end
    end

    // A dropped store raises o_wr_err for the single cycle after it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_err <= 1'b0;
        end else begin
            o_wr_err <= i_wr_req && wr_bad;
        end
    end

    assign o_rd_valid = pipe_valid[NSTG-1];
    assign o_rd_err   = pipe_err[NSTG-1];
    assign o_rd_data  = pipe_data[NSTG-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed testbench for data_mem_responder with DEPTH_WORDS=1024 and
// READ_LAT=2. Inputs change on the falling edge, and outputs are sampled on
// the falling edge. Expected values are written by hand. Where the result
// depends on DATA_MEM_STORE_FWD_EN, the bench picks the value for the build
// it is compiled in.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH_WORDS = 1024;
    localparam int READ_LAT    = 2;
`ifdef DATA_MEM_STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_rd_req = 1'b0;
    logic [31:0] i_rd_addr = '0;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic        o_rd_err;
    logic        i_wr_req = 1'b0;
    logic [31:0] i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic [3:0]  i_wr_be = '0;
    logic        o_wr_err;

    int compared   = 0;
    int mismatched = 0;

    always #5 i_clk = ~i_clk;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .READ_LAT    (READ_LAT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_req   (i_rd_req),
        .i_rd_addr  (i_rd_addr),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data),
        .o_rd_err   (o_rd_err),
        .i_wr_req   (i_wr_req),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_wr_be    (i_wr_be),
        .o_wr_err   (o_wr_err)
    );

    // Drive one store for a single cycle. The task is called just after a
    // falling edge and returns at the next falling edge.
    task automatic store_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d; i_wr_be = be;
        @(negedge i_clk);
        i_wr_req = 1'b0; i_wr_be = 4'h0;
    endtask

    // Issue one load and wait, within a bounded number of cycles, for its
    // response. lat is the number of rising edges after the acceptance edge,
    // or -1 if no response arrived. The task returns one falling edge after
    // the response, so the caller can check that the pulse has ended.
    task automatic load_word(input logic [31:0] a, output int lat,
                             output logic [31:0] d, output logic e);
        i_rd_req = 1'b1; i_rd_addr = a;
        @(negedge i_clk);
        i_rd_req = 1'b0;
        lat = 0;
        while (!o_rd_valid && lat < 10) begin
            @(negedge i_clk);
            lat++;
        end
        d = o_rd_data;
        e = o_rd_err;
        if (!o_rd_valid) lat = -1;
        @(negedge i_clk);
    endtask

    task automatic test_reset;
        #1 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        compared++; if (o_rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", o_rd_valid); end
        compared++; if (o_rd_data !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rd_data: got %h expected 00000000", o_rd_data); end
        compared++; if (o_rd_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_err: got %b expected 0", o_rd_err); end
        compared++; if (o_wr_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr_err: got %b expected 0", o_wr_err); end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        compared++; if (o_rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_valid: got %b expected 0", o_rd_valid); end
    endtask

    task automatic test_basic;
        int lat; logic [31:0] d; logic e;
        store_word(32'h10, 32'hDEADBEEF, 4'hF);
        load_word(32'h10, lat, d, e);
        compared++; if (lat != READ_LAT) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, READ_LAT); end
        compared++; if (d !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL basic_data: got %h expected deadbeef", d); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_err: got %b expected 0", e); end
        compared++; if (o_rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_pulse_width: got %b expected 0", o_rd_valid); end
    endtask

    task automatic test_byte_enable;
        int lat; logic [31:0] d; logic e;
        store_word(32'h20, 32'hAABBCCDD, 4'hF);
        store_word(32'h20, 32'h11223344, 4'b0101);
        load_word(32'h20, lat, d, e);
        compared++; if (d !== 32'hAA22CC44) begin mismatched++; $display("[TB] FAIL be_merge_data: got %h expected aa22cc44", d); end
        compared++; if (e !== 1'b0) begin mismatched++; $display("[TB] FAIL be_merge_err: got %b expected 0", e); end
        store_word(32'h20, 32'hFFFFFFFF, 4'h0);
        load_word(32'h20, lat, d, e);
        compared++; if (d !== 32'hAA22CC44) begin mismatched++; $display("[TB] FAIL be_zero_noop: got %h expected aa22cc44", d); end
        compared++; if (o_wr_err !== 1'b0) begin mismatched++; $display("[TB] FAIL be_zero_wr_err: got %b expected 0", o_wr_err); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] resp [4];
        int          resp_cyc [4];
        int          got;
        logic [31:0] exp_w;
        for (int i = 0; i < 4; i++) store_word(32'(i * 4), 32'(i + 1), 4'hF);
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin i_rd_req = 1'b1; i_rd_addr = 32'(c * 4); end
            else i_rd_req = 1'b0;
            @(negedge i_clk);
            if (o_rd_valid) begin
                if (got < 4) begin resp[got] = o_rd_data; resp_cyc[got] = c; end
                got++;
            end
        end
        i_rd_req = 1'b0;
        compared++; if (got != 4) begin mismatched++; $display("[TB] FAIL stream_count: got %0d expected 4", got); end
        if (got >= 4) begin
            for (int i = 0; i < 4; i++) begin
                exp_w = 32'(i + 1);
                compared++; if (resp[i] !== exp_w) begin mismatched++; $display("[TB] FAIL stream_data_%0d: got %h expected %h", i, resp[i], exp_w); end
            end
            compared++; if (resp_cyc[3] - resp_cyc[0] != 3) begin mismatched++; $display("[TB] FAIL stream_consecutive: got span %0d expected 3", resp_cyc[3] - resp_cyc[0]); end
        end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] d; logic e;
        load_word(32'h6, lat, d, e);
        compared++; if (lat != READ_LAT) begin mismatched++; $display("[TB] FAIL misalign_latency: got %0d expected %0d", lat, READ_LAT); end
        compared++; if (e !== 1'b1) begin mismatched++; $display("[TB] FAIL misalign_err: got %b expected 1", e); end
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL misalign_data: got %h expected 00000000", d); end
        load_word(32'(4 * DEPTH_WORDS), lat, d, e);
        compared++; if (e !== 1'b1) begin mismatched++; $display("[TB] FAIL range_err: got %b expected 1", e); end
        compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL range_data: got %h expected 00000000", d); end
        i_wr_req = 1'b1; i_wr_addr = 32'h3; i_wr_data = 32'hFFFFFFFF; i_wr_be = 4'hF;
        @(negedge i_clk);
        i_wr_req = 1'b0; i_wr_be = 4'h0;
        compared++; if (o_wr_err !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_misalign_err: got %b expected 1", o_wr_err); end
        @(negedge i_clk);
        compared++; if (o_wr_err !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_err_one_cycle: got %b expected 0", o_wr_err); end
        load_word(32'h0, lat, d, e);
        compared++; if (d !== 32'h1) begin mismatched++; $display("[TB] FAIL wr_misalign_unchanged: got %h expected 00000001", d); end
        i_wr_req = 1'b1; i_wr_addr = 32'(4 * DEPTH_WORDS); i_wr_data = 32'hFFFFFFFF; i_wr_be = 4'hF;
        @(negedge i_clk);
        i_wr_req = 1'b0; i_wr_be = 4'h0;
        compared++; if (o_wr_err !== 1'b1) begin mismatched++; $display("[TB] FAIL wr_range_err: got %b expected 1", o_wr_err); end
        load_word(32'h0, lat, d, e);
        compared++; if (d !== 32'h1) begin mismatched++; $display("[TB] FAIL wr_range_unchanged: got %h expected 00000001", d); end
    endtask

    task automatic test_hazard;
        int lat; logic [31:0] d; logic e; logic [31:0] exp_w;
        store_word(32'h40, 32'd5, 4'hF);
        // Load and store to the same word in the same cycle.
        i_rd_req = 1'b1; i_rd_addr = 32'h40;
        i_wr_req = 1'b1; i_wr_addr = 32'h40; i_wr_data = 32'd9; i_wr_be = 4'hF;
        @(negedge i_clk);
        i_rd_req = 1'b0; i_wr_req = 1'b0; i_wr_be = 4'h0;
        lat = 0;
        while (!o_rd_valid && lat < 10) begin @(negedge i_clk); lat++; end
        exp_w = FWD ? 32'd9 : 32'd5;
        compared++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_w) begin mismatched++; $display("[TB] FAIL same_cycle_hazard: got valid=%b data=%h expected valid=1 data=%h", o_rd_valid, o_rd_data, exp_w); end
        @(negedge i_clk);
        store_word(32'h40, 32'd5, 4'hF);
        // Store arrives one cycle after the load, while the load is in flight.
        i_rd_req = 1'b1; i_rd_addr = 32'h40;
        @(negedge i_clk);
        i_rd_req = 1'b0;
        i_wr_req = 1'b1; i_wr_addr = 32'h40; i_wr_data = 32'd7; i_wr_be = 4'hF;
        @(negedge i_clk);
        i_wr_req = 1'b0; i_wr_be = 4'h0;
        lat = 0;
        while (!o_rd_valid && lat < 10) begin @(negedge i_clk); lat++; end
        exp_w = FWD ? 32'd7 : 32'd5;
        compared++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp_w) begin mismatched++; $display("[TB] FAIL inflight_hazard: got valid=%b data=%h expected valid=1 data=%h", o_rd_valid, o_rd_data, exp_w); end
        @(negedge i_clk);
        load_word(32'h40, lat, d, e);
        compared++; if (d !== 32'd7) begin mismatched++; $display("[TB] FAIL hazard_store_landed: got %h expected 00000007", d); end
    endtask

    task automatic test_reset_midflight;
        int lat; logic [31:0] d; logic e; int seen;
        i_rd_req = 1'b1; i_rd_addr = 32'h10;
        @(negedge i_clk);
        i_rd_req = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        compared++; if (o_rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midflight_in_reset: got %b expected 0", o_rd_valid); end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_rd_valid) seen++;
        end
        compared++; if (seen != 0) begin mismatched++; $display("[TB] FAIL midflight_discard: got %0d responses expected 0", seen); end
        load_word(32'h10, lat, d, e);
        compared++; if (d !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL midflight_array_kept: got %h expected deadbeef", d); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_byte_enable;
        test_back_to_back;
        test_errors;
        test_hazard;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
